// File: rtl/harness_cmd_tx.sv
// harness_cmd_tx: turns host requests into the harness command byte stream
// and assembles the sampled output bytes returned by the harness into words.
// Optional build macro HARNESS_CMD_TX_TIMEOUT_EN enables the response timeout
// (err_flags[2]); without it WAIT_RESP waits indefinitely.
module harness_cmd_tx #(
    parameter int INPUT_BYTES    = 4,
    parameter int OUTPUT_WORDS   = 1,
    parameter int COUNT_W        = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_op,
    input  logic [INPUT_BYTES*8-1:0]  req_data,
    input  logic [COUNT_W-1:0]        req_count,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [7:0]                tx_byte,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_byte,
    output logic                      resp_valid,
    output logic [OUTPUT_WORDS*32-1:0] resp_data,
    output logic                      busy,
    output logic                      halted,
    output logic [2:0]                err_flags
);

    localparam int RESP_BYTES = 4 * OUTPUT_WORDS;
    localparam int IDX_MAX    = (INPUT_BYTES > RESP_BYTES) ? INPUT_BYTES : RESP_BYTES;
    localparam int IDX_W      = $clog2(IDX_MAX) + 1;

    localparam logic [2:0] OP_RST_ON  = 3'd0;
    localparam logic [2:0] OP_RST_OFF = 3'd1;
    localparam logic [2:0] OP_STEP    = 3'd2;
    localparam logic [2:0] OP_LOAD    = 3'd3;
    localparam logic [2:0] OP_SAMPLE  = 3'd4;
    localparam logic [2:0] OP_QUIT    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_PAYLOAD,
        S_STEP_REP,
        S_WAIT_RESP,
        S_HALT
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                op_q, op_d;
    logic [INPUT_BYTES*8-1:0]  data_q, data_d;
    logic [COUNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [RESP_BYTES*8-1:0]   resp_q, resp_d;
    logic                      resp_valid_q, resp_valid_d;
    logic                      ready_q, ready_d;
    logic [2:0]                err_q, err_d;
    logic [7:0]                op_byte;

`ifdef HARNESS_CMD_TX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
`endif

    // Opcode byte for the captured request
    always_comb begin
        op_byte = 8'h00;
        case (op_q)
            OP_RST_ON:  op_byte = 8'h6A;
            OP_RST_OFF: op_byte = 8'h6B;
            OP_STEP:    op_byte = 8'h6C;
            OP_LOAD:    op_byte = 8'h6D;
            OP_SAMPLE:  op_byte = 8'h68;
            OP_QUIT:    op_byte = 8'h69;
            default:    op_byte = 8'h00;
        endcase
    end

    // Next-state, byte sequencing and response capture
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves a latch.
        state_d      = state_q;
        op_d         = op_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        resp_d       = resp_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        tx_valid     = 1'b0;
        tx_byte      = 8'h00;
`ifdef HARNESS_CMD_TX_TIMEOUT_EN
        tmo_d        = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    op_d   = req_op;
                    data_d = req_data;
                    cnt_d  = req_count;
                    idx_d  = '0;
                    case (req_op)
                        OP_RST_ON, OP_RST_OFF, OP_LOAD, OP_SAMPLE, OP_QUIT:
                            state_d = S_OPCODE;
                        OP_STEP:
                            state_d = S_STEP_REP;
                        default:
                            err_d[0] = 1'b1;
                    endcase
                end
            end

            S_OPCODE: begin
                tx_valid = 1'b1;
                tx_byte  = op_byte;
                if (tx_ready) begin
                    case (op_q)
                        OP_LOAD:   state_d = S_PAYLOAD;
                        OP_SAMPLE: state_d = S_WAIT_RESP;
                        OP_QUIT:   state_d = S_HALT;
                        default:   state_d = S_IDLE;
                    endcase
                end
            end

            S_PAYLOAD: begin
                tx_valid = 1'b1;
                tx_byte  = data_q[7:0];
                if (tx_ready) begin
                    data_d = data_q >> 8;
                    if (idx_q == IDX_W'(INPUT_BYTES - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_STEP_REP: begin
                // A zero count spends one cycle here with nothing presented
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tx_valid = 1'b1;
                    tx_byte  = 8'h6C;
                    if (tx_ready) begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == COUNT_W'(1)) begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            S_WAIT_RESP: begin
                if (rx_valid) begin
                    resp_d[{idx_q, 3'b000} +: 8] = rx_byte;
                    if (idx_q == IDX_W'(RESP_BYTES - 1)) begin
                        state_d      = S_IDLE;
                        resp_valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
`ifdef HARNESS_CMD_TX_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = S_IDLE;
                    err_d[2] = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response bytes are only expected while waiting for a sample
        if (rx_valid && (state_q != S_WAIT_RESP)) begin
            err_d[1] = 1'b1;
        end

        // Registered so that ready stays low for the first cycle after reset
        ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            err_q        <= '0;
`ifdef HARNESS_CMD_TX_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignment only.
            state_q      <= state_d;
            op_q         <= op_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            resp_q       <= resp_d;
            resp_valid_q <= resp_valid_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
`ifdef HARNESS_CMD_TX_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_q;
    assign busy       = (state_q != S_IDLE);
    assign halted     = (state_q == S_HALT);
`ifdef HARNESS_CMD_TX_TIMEOUT_EN
    assign err_flags  = err_q;
`else
    assign err_flags  = {1'b0, err_q[1:0]};
`endif

endmodule

// File: tb/tb_harness_cmd_tx.sv
// Self-checking bench for harness_cmd_tx: random requests scored against a
// byte-list model of the command protocol.
module tb_harness_cmd_tx;

    localparam int IB = 4;
    localparam int OW = 2;
    localparam int CW = 4;
    localparam int TO = 16;
    localparam int RB = 4 * OW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_op = '0;
    logic [IB*8-1:0]   req_data = '0;
    logic [CW-1:0]     req_count = '0;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_byte;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_byte = '0;
    logic              resp_valid;
    logic [OW*32-1:0]  resp_data;
    logic              busy;
    logic              halted;
    logic [2:0]        err_flags;

    harness_cmd_tx #(
        .INPUT_BYTES(IB), .OUTPUT_WORDS(OW), .COUNT_W(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_count(req_count),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
        .rx_valid(rx_valid), .rx_byte(rx_byte),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(busy), .halted(halted), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference state
    logic [7:0]       expq[$];
    logic [7:0]       txq[$];
    logic [2:0]       exp_err  = '0;
    logic [OW*32-1:0] exp_resp = '0;
    int               resp_pulses = 0;
    bit               rand_ready  = 1'b0;
    logic             fixed_ready = 1'b1;
    bit               prev_stall  = 1'b0;
    logic [7:0]       prev_byte   = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream acceptance: fixed or random per cycle
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
        end
    end

    // Monitor: log handshaken bytes, check hold-while-stalled, count pulses
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(tx_valid), 64'd1);
                check("stall_byte", 64'(tx_byte), 64'(prev_byte));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_byte  = tx_byte;
            if (tx_valid && tx_ready) txq.push_back(tx_byte);
            if (resp_valid) resp_pulses++;
        end
    end

    // Protocol model: the byte list a request must produce
    task automatic build_exp(input logic [2:0] op, input logic [IB*8-1:0] d, input logic [CW-1:0] c);
        expq.delete();
        case (op)
            3'd0: expq.push_back(8'h6A);
            3'd1: expq.push_back(8'h6B);
            3'd2: for (int i = 0; i < int'(c); i++) expq.push_back(8'h6C);
            3'd3: begin
                expq.push_back(8'h6D);
                for (int i = 0; i < IB; i++) expq.push_back(8'((d >> (8 * i)) & 8'hFF));
            end
            3'd4: expq.push_back(8'h68);
            3'd5: expq.push_back(8'h69);
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [IB*8-1:0] d, input logic [CW-1:0] c);
        int n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        check("ready_before_req", 64'(req_ready), 64'd1);
        txq.delete();
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_count = c;
        tick();
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_data  = $urandom;
        req_count = CW'($urandom);
    endtask

    task automatic compare_tx(input string tag);
        check({tag, "_count"}, 64'(txq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < txq.size(); i++)
            check({tag, "_byte"}, 64'(txq[i]), 64'(expq[i]));
    endtask

    // Non-sample request; with timing set, tx_ready must be held at 1
    task automatic run_req(input logic [2:0] op, input logic [IB*8-1:0] d, input logic [CW-1:0] c,
                           input bit timing);
        int  cyc = 0;
        bit  ready_seen = 1'b0;
        int  exp_cyc;
        build_exp(op, d, c);
        issue(op, d, c);
        while (busy && !halted && cyc < 200) begin
            if (req_ready) ready_seen = 1'b1;
            tick();
            cyc++;
        end
        check("busy_bounded", 64'(cyc < 200), 64'd1);
        check("ready_low_busy", 64'(ready_seen), 64'd0);
        if (timing) begin
            exp_cyc = (op == 3'd2 && c == '0) ? 1 : expq.size();
            check("busy_cycles", 64'(cyc), 64'(exp_cyc));
        end
        compare_tx("tx");
        if (op > 3'd5) exp_err[0] = 1'b1;
        check("err_flags", 64'(err_flags), 64'(exp_err));
        check("resp_hold", 64'(resp_data), 64'(exp_resp));
    endtask

    // Issue SAMPLE, wait for 0x68, return bytes with random gaps
    task automatic run_sample(input int nbytes);
        int n = 0;
        int pulses0;
        logic [7:0] b;
        build_exp(3'd4, '0, '0);
        issue(3'd4, '0, '0);
        while (txq.size() == 0 && n < 100) begin tick(); n++; end
        compare_tx("sample_tx");
        pulses0 = resp_pulses;
        for (int k = 0; k < nbytes; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            b = 8'($urandom);
            rx_valid = 1'b1;
            rx_byte  = b;
            exp_resp[8*k +: 8] = b;
            tick();
            rx_valid = 1'b0;
            if (k < RB - 1) check("sample_busy", 64'(busy), 64'd1);
        end
        if (nbytes == RB) begin
            check("resp_valid_pulse", 64'(resp_valid), 64'd1);
            check("resp_idle", 64'(busy), 64'd0);
            check("resp_data", 64'(resp_data), 64'(exp_resp));
            tick();
            check("resp_valid_drop", 64'(resp_valid), 64'd0);
            check("resp_pulse_count", 64'(resp_pulses - pulses0), 64'd1);
        end
`ifdef HARNESS_CMD_TX_TIMEOUT_EN
        else begin
            n = 0;
            while (busy && n < 100) begin tick(); n++; end
            check("timeout_cycles", 64'(n), 64'(TO));
            exp_err[2] = 1'b1;
            check("timeout_err", 64'(err_flags), 64'(exp_err));
            check("timeout_no_pulse", 64'(resp_pulses - pulses0), 64'd0);
            check("timeout_partial", 64'(resp_data), 64'(exp_resp));
        end
`endif
        check("sample_err", 64'(err_flags), 64'(exp_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        logic [CW-1:0] c;

        // Reset state
        tick();
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_err", 64'(err_flags), 64'd0);
        check("rst_resp", 64'(resp_data), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        tick(); tick();
        rst = 1'b0;
        check("ready_still_low", 64'(req_ready), 64'd0);
        tick();
        check("ready_after_rst", 64'(req_ready), 64'd1);

        // Directed back-to-back with full acceptance
        rand_ready = 1'b0; fixed_ready = 1'b1;
        run_req(3'd0, 32'h0, '0, 1'b1);
        run_req(3'd3, 32'hA1B2C3D4, '0, 1'b1);
        run_req(3'd1, 32'h0, '0, 1'b1);
        run_req(3'd2, 32'h0, CW'(0), 1'b1);

        // Stalling downstream
        rand_ready = 1'b1;
        run_req(3'd2, 32'h0, CW'(3), 1'b0);
        run_req(3'd2, 32'h0, {CW{1'b1}}, 1'b0);
        run_sample(RB);

        // Stray response byte and illegal op
        rx_valid = 1'b1; rx_byte = 8'h5A;
        tick();
        rx_valid = 1'b0;
        exp_err[1] = 1'b1;
        check("unexpected_rx", 64'(err_flags), 64'(exp_err));
        rand_ready = 1'b0;
        run_req(3'd7, 32'h0, '0, 1'b1);
        check("err_011", 64'(err_flags), 64'(exp_err));

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            rand_ready  = ($urandom_range(0, 1) == 1);
            fixed_ready = 1'b1;
            op = 3'($urandom_range(0, 7));
            if (op == 3'd5) op = 3'd6;
            c  = ($urandom_range(0, 3) == 0) ? {CW{1'b1}} : CW'($urandom);
            if (op == 3'd4) run_sample(RB);
            else run_req(op, $urandom, c, !rand_ready);
        end

`ifdef HARNESS_CMD_TX_TIMEOUT_EN
        rand_ready = 1'b0;
        run_sample(3);
`endif

        // QUIT and recovery
        rand_ready = 1'b0;
        run_req(3'd5, 32'h0, '0, 1'b1);
        check("halted", 64'(halted), 64'd1);
        req_valid = 1'b1; req_op = 3'd0;
        repeat (3) tick();
        check("halt_ready", 64'(req_ready), 64'd0);
        check("halt_no_tx", 64'(txq.size()), 64'd1);
        rst = 1'b1;
        tick(); tick();
        check("rst_clears_halt", 64'(halted), 64'd0);
        check("rst_clears_err", 64'(err_flags), 64'd0);
        check("rst_clears_resp", 64'(resp_data), 64'd0);
        req_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("ready_after_rerst", 64'(req_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
